prog_seq: RTL and testbench
===========================

# prog_seq

Parametrised program sequencer: the next-generation program counter for the single-cycle core, sitting between the test-bench start handshake and instruction memory. It supports `NPROG` programs at a fixed address stride and gates execution with a start handshake state machine. It adds absolute, conditional-relative, call and return control flow, the last two through a small return-address stack, plus a pipeline stall input.

## Interface
Parameters:
- `A`, 10: instruction-address width; `ProgCtr` width.
- `REL_W`, 8: width of the signed relative branch offset.
- `NPROG`, 3: number of programs selectable by successive Start pulses (1..16).
- `PROG_STRIDE`, 100: address distance between program base addresses; base(i) = i*PROG_STRIDE, truncated to `A` bits.
- `RAS_DEPTH`, 4: return-address-stack entries (power of two, ≥2).

Ports:
- `Clk` in 1: sole clock; all state updates on posedge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: test-bench program request, level pulse of any length ≥1 cycle.
- `Stall` in 1: hold PC and stack this cycle.
- `BranchAbsEn` in 1: absolute jump to `AbsTarget` when `ALU_flag`=0.
- `BranchRelEn` in 1: relative jump `ProgCtr`+`RelTarget` when `ALU_flag`=0.
- `CallEn` in 1: unconditional call to `AbsTarget`; pushes `ProgCtr`+1.
- `RetEn` in 1: unconditional return; pops stack into `ProgCtr`.
- `ALU_flag` in 1: branch condition, taken when low.
- `AbsTarget` in A: absolute/call target.
- `RelTarget` in REL_W: signed two's-complement offset.
- `ProgCtr` out A: registered program counter.
- `Running` out 1: high in RUN state.
- `ProgIdx` out 4: index of current program (0-based).
- `RasOverflow` out 1: sticky, push while full.
- `RasUnderflow` out 1: sticky, pop while empty.

## Operation
- States: IDLE (after reset, PC frozen), HOLD (Start high, PC frozen), RUN.
- IDLE/RUN --Start rising--> HOLD; `start_r` registers previous `Start`.
- HOLD --Start falling--> RUN; on that edge `ProgCtr`<=base(`ProgIdx` next), stack cleared (empty), sticky flags kept.
- Program index: first Start selects 0; each later Start increments; after `NPROG`-1 wraps to 0.
- In RUN, per cycle, first match wins: `Stall` -> hold; `RetEn` -> pop; `CallEn` -> push PC+1, PC<=`AbsTarget`; `BranchAbsEn`&!`ALU_flag` -> PC<=`AbsTarget`; `BranchRelEn`&!`ALU_flag` -> PC<=PC+sext(`RelTarget`); else PC<=PC+1.
- Control-flow inputs ignored outside RUN.
- Arithmetic modulo 2^A: PC+1 at 2^A-1 yields 0; relative sum sign-extended to A bits then truncated.
- Stack: circular, depth `RAS_DEPTH`. Push when full overwrites oldest entry, sets `RasOverflow`, count stays full. Pop when empty: PC<=PC+1, sets `RasUnderflow`.
- Simultaneous `RetEn`&`CallEn`: return wins, no push.

## Timing
- All outputs registered; a control input sampled at edge n affects `ProgCtr` after edge n.
- Reset values: `ProgCtr`=0, `Running`=0, `ProgIdx`=0, flags=0, stack empty, state IDLE, `start_r`=0.
- Start rising edge seen at the first clock with `Start`=1; `Running` drops the cycle after.
- Falling edge: `ProgCtr`=base and `Running`=1 visible after the clock where `Start`=0, `start_r`=1.
- 1-cycle Start pulse: HOLD for exactly one cycle, then RUN.
- Reset mid-program or mid-HOLD: everything returns to reset values at the next edge; next Start selects program 0.

## Structure
- `prog_seq_pkg`: state enum (IDLE/HOLD/RUN), PC-op enum (HOLD/INC/ABS/REL/CALL/RET), base-address function.
- Sub-module `ret_addr_stack`: push/pop/clear, full/empty, overflow/underflow detection, parametrised by `A`, `RAS_DEPTH`.

## Test plan
- Reset, no Start for 10 cycles -> `ProgCtr`=0, `Running`=0 throughout.
- Start pulses 3 cycles then low -> `ProgCtr`=0, `Running`=1, then 1,2,3; second pulse -> 100; third -> 200; fourth -> 0, `ProgIdx`=0.
- RUN at PC=10: `BranchRelEn`, `RelTarget`=0xFB, `ALU_flag`=0 -> PC=5; same with `ALU_flag`=1 -> PC=11.
- PC=20 `CallEn` `AbsTarget`=300 -> 300; later `RetEn` -> 21; five nested calls at `RAS_DEPTH`=4 -> `RasOverflow`=1, returns unwind the four newest addresses.
- `RetEn` on empty stack at PC=40 -> PC=41, `RasUnderflow`=1 until Reset.
- `Stall` held 3 cycles with `BranchAbsEn` -> PC unchanged; PC at 1023 with no branch -> 0.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// prog_seq shared types: sequencer states, PC operations
// and the program base-address helper.
package prog_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN
    } seq_state_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_ABS,
        OP_REL,
        OP_CALL,
        OP_RET
    } pc_op_t;

    // Full-width base address; callers truncate to their PC width.
    function automatic logic [31:0] base_addr(
        input logic [3:0]  idx,
        input int unsigned stride
    );
        return 32'(idx) * stride;
    endfunction

endpackage

// File: rtl/prog_seq_if.sv
// prog_seq control/status bundle: start handshake, control flow
// requests from the core, and the registered sequencer outputs.
interface prog_seq_if #(
    parameter int A     = 10,
    parameter int REL_W = 8
);
    logic             Start;
    logic             Stall;
    logic             BranchAbsEn;
    logic             BranchRelEn;
    logic             CallEn;
    logic             RetEn;
    logic             ALU_flag;
    logic [A-1:0]     AbsTarget;
    logic [REL_W-1:0] RelTarget;
    logic [A-1:0]     ProgCtr;
    logic             Running;
    logic [3:0]       ProgIdx;
    logic             RasOverflow;
    logic             RasUnderflow;

    modport master (
        output Start, Stall, BranchAbsEn, BranchRelEn,
        output CallEn, RetEn, ALU_flag, AbsTarget, RelTarget,
        input  ProgCtr, Running, ProgIdx,
        input  RasOverflow, RasUnderflow
    );

    modport slave (
        input  Start, Stall, BranchAbsEn, BranchRelEn,
        input  CallEn, RetEn, ALU_flag, AbsTarget, RelTarget,
        output ProgCtr, Running, ProgIdx,
        output RasOverflow, RasUnderflow
    );
endinterface

// File: rtl/prog_seq_ret_addr_stack.sv
// Circular return-address stack: a push while full overwrites
// the oldest entry; sticky overflow/underflow survive clear.
module ret_addr_stack #(
    parameter int A         = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [A-1:0] push_data,
    output logic [A-1:0] top_data,
    output logic         empty,
    output logic         overflow,
    output logic         underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0] P_ONE = 1;
    localparam logic [PW:0]   C_ONE = 1;
    localparam logic [PW:0]   C_MAX = (PW+1)'(RAS_DEPTH);

    logic [A-1:0]  mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;

    assign rd_ptr   = ptr - P_ONE;
    assign full     = (count == C_MAX);
    assign empty    = (count == '0);
    assign top_data = mem[rd_ptr];

    // Entry storage: written at the pointer on every accepted push.
    always_ff @(posedge Clk) begin
        if (!Reset && !clear && push) begin
            mem[ptr] <= push_data;
        end
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + P_ONE;
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + C_ONE;
            end
        end else if (pop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                ptr   <= rd_ptr;
                count <= count - C_ONE;
            end
        end
    end
endmodule

// File: rtl/prog_seq.sv
// Program sequencer: start handshake FSM selecting one of NPROG
// programs, then PC control with branches, call/return, stall.
module prog_seq
    import prog_seq_pkg::*;
#(
    parameter int A           = 10,
    parameter int REL_W       = 8,
    parameter int NPROG       = 3,
    parameter int PROG_STRIDE = 100,
    parameter int RAS_DEPTH   = 4
) (
    input logic     Clk,
    input logic     Reset,
    prog_seq_if.slave bus
);
    localparam logic [A-1:0] PC_ONE   = 1;
    localparam logic [3:0]   IDX_LAST = 4'(NPROG - 1);
    localparam logic [3:0]   IDX_ONE  = 1;

    seq_state_t   state;
    pc_op_t       op;
    logic         start_r;
    logic         started;
    logic         running;
    logic [3:0]   prog_idx;
    logic [3:0]   idx_nxt;
    logic [A-1:0] pc;
    logic [A-1:0] pc_inc;
    logic [A-1:0] rel_ext;
    logic [A-1:0] base;
    logic         rise;
    logic         fall;
    logic [A-1:0] ras_top;
    logic         ras_empty;
    logic         ras_ovf;
    logic         ras_unf;

    assign rise    = bus.Start & ~start_r;
    assign fall    = ~bus.Start & start_r;
    assign pc_inc  = pc + PC_ONE;
    assign rel_ext = {{(A-REL_W){bus.RelTarget[REL_W-1]}},
                      bus.RelTarget};
    assign base    = A'(base_addr(prog_idx, PROG_STRIDE));

    // First Start picks program 0; later ones step and wrap.
    always_comb begin
        idx_nxt = '0;
        if (started && prog_idx != IDX_LAST) begin
            idx_nxt = prog_idx + IDX_ONE;
        end
    end

    // PC operation for this cycle, first match wins; a Start
    // rising edge freezes the PC while entering HOLD.
    always_comb begin
        op = OP_HOLD;
        if (state == ST_RUN && !rise) begin
            if (bus.Stall)
                op = OP_HOLD;
            else if (bus.RetEn)
                op = OP_RET;
            else if (bus.CallEn)
                op = OP_CALL;
            else if (bus.BranchAbsEn && !bus.ALU_flag)
                op = OP_ABS;
            else if (bus.BranchRelEn && !bus.ALU_flag)
                op = OP_REL;
            else
                op = OP_INC;
        end
    end

    ret_addr_stack #(
        .A         (A),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (state == ST_HOLD && fall),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    // Start handshake FSM and program counter update.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            start_r  <= 1'b0;
            started  <= 1'b0;
            running  <= 1'b0;
            prog_idx <= '0;
            pc       <= '0;
        end else begin
            start_r <= bus.Start;
            unique case (state)
                ST_IDLE, ST_RUN: begin
                    if (rise) begin
                        state    <= ST_HOLD;
                        running  <= 1'b0;
                        started  <= 1'b1;
                        prog_idx <= idx_nxt;
                    end
                end
                ST_HOLD: begin
                    if (fall) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        pc      <= base;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            unique case (op)
                OP_INC:  pc <= pc_inc;
                OP_ABS:  pc <= bus.AbsTarget;
                OP_CALL: pc <= bus.AbsTarget;
                OP_REL:  pc <= pc + rel_ext;
                OP_RET:  pc <= ras_empty ? pc_inc : ras_top;
                default: ;
            endcase
        end
    end

    assign bus.ProgCtr      = pc;
    assign bus.Running      = running;
    assign bus.ProgIdx      = prog_idx;
    assign bus.RasOverflow  = ras_ovf;
    assign bus.RasUnderflow = ras_unf;
endmodule

// File: tb/tb_prog_seq.sv
// prog_seq bench: directed vectors push expected outputs into a
// queue; a monitor pops and compares one entry per clock.
module tb_prog_seq;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic [9:0] pc;
        logic       run;
        logic [3:0] idx;
        logic       ovf;
        logic       unf;
    } obs_t;

    logic Clk = 1'b0;
    logic Reset;
    obs_t exp_q[$];
    obs_t e_m;
    obs_t a_m;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    prog_seq_if #(.A(10), .REL_W(8)) bus();

    prog_seq #(
        .A           (10),
        .REL_W       (8),
        .NPROG       (3),
        .PROG_STRIDE (100),
        .RAS_DEPTH   (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic ctl(
        input logic       st,
        input logic       stl,
        input logic       babs,
        input logic       brel,
        input logic       call,
        input logic       ret,
        input logic       flg,
        input logic [9:0] abs_t,
        input logic [7:0] rel_t
    );
        bus.Start       = st;
        bus.Stall       = stl;
        bus.BranchAbsEn = babs;
        bus.BranchRelEn = brel;
        bus.CallEn      = call;
        bus.RetEn       = ret;
        bus.ALU_flag    = flg;
        bus.AbsTarget   = abs_t;
        bus.RelTarget   = rel_t;
    endtask

    task automatic nop();
        ctl(L, L, L, L, L, L, L, 10'd0, 8'h00);
    endtask

    // Queue the outputs expected after the next rising edge.
    task automatic tick(
        input logic [9:0] pc,
        input logic       run,
        input logic [3:0] idx,
        input logic       ovf,
        input logic       unf
    );
        obs_t e;
        e.pc  = pc;
        e.run = run;
        e.idx = idx;
        e.ovf = ovf;
        e.unf = unf;
        exp_q.push_back(e);
        @(negedge Clk);
    endtask

    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_m = exp_q.pop_front();
            a_m = {bus.ProgCtr, bus.Running, bus.ProgIdx,
                   bus.RasOverflow, bus.RasUnderflow};
            checks++;
            if (a_m !== e_m) begin
                errors++;
                $display("FAIL outputs t=%0t got pc=%0d run=%b idx=%0d ovf=%b unf=%b required pc=%0d run=%b idx=%0d ovf=%b unf=%b",
                         $time, a_m.pc, a_m.run, a_m.idx, a_m.ovf,
                         a_m.unf, e_m.pc, e_m.run, e_m.idx, e_m.ovf,
                         e_m.unf);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        nop();
        tick(10'd0, L, 4'd0, L, L);
        Reset = 1'b0;
        repeat (10) tick(10'd0, L, 4'd0, L, L);

        // Program 0: three-cycle Start pulse.
        ctl(H, L, L, L, L, L, L, 10'd0, 8'h00);
        repeat (3) tick(10'd0, L, 4'd0, L, L);
        nop();
        tick(10'd0, H, 4'd0, L, L);
        for (int i = 1; i <= 10; i++) tick(10'(i), H, 4'd0, L, L);

        // Branches.
        ctl(L, L, L, H, L, L, L, 10'd0, 8'hFB);
        tick(10'd5, H, 4'd0, L, L);
        ctl(L, L, H, L, L, L, L, 10'd10, 8'h00);
        tick(10'd10, H, 4'd0, L, L);
        ctl(L, L, L, H, L, L, H, 10'd0, 8'hFB);
        tick(10'd11, H, 4'd0, L, L);
        ctl(L, L, H, L, L, L, H, 10'd20, 8'h00);
        tick(10'd12, H, 4'd0, L, L);
        ctl(L, L, H, L, L, L, L, 10'd20, 8'h00);
        tick(10'd20, H, 4'd0, L, L);

        // Call and return.
        ctl(L, L, L, L, H, L, L, 10'd300, 8'h00);
        tick(10'd300, H, 4'd0, L, L);
        nop();
        tick(10'd301, H, 4'd0, L, L);
        ctl(L, L, L, L, L, H, L, 10'd0, 8'h00);
        tick(10'd21, H, 4'd0, L, L);

        // Five nested calls overflow a four-deep stack.
        ctl(L, L, L, L, H, L, L, 10'd500, 8'h00);
        tick(10'd500, H, 4'd0, L, L);
        ctl(L, L, L, L, H, L, L, 10'd600, 8'h00);
        tick(10'd600, H, 4'd0, L, L);
        ctl(L, L, L, L, H, L, L, 10'd700, 8'h00);
        tick(10'd700, H, 4'd0, L, L);
        ctl(L, L, L, L, H, L, L, 10'd800, 8'h00);
        tick(10'd800, H, 4'd0, L, L);
        ctl(L, L, L, L, H, L, L, 10'd900, 8'h00);
        tick(10'd900, H, 4'd0, H, L);
        ctl(L, L, L, L, L, H, L, 10'd0, 8'h00);
        tick(10'd801, H, 4'd0, H, L);
        tick(10'd701, H, 4'd0, H, L);
        tick(10'd601, H, 4'd0, H, L);
        tick(10'd501, H, 4'd0, H, L);

        // Return on empty stack.
        ctl(L, L, H, L, L, L, L, 10'd40, 8'h00);
        tick(10'd40, H, 4'd0, H, L);
        ctl(L, L, L, L, L, H, L, 10'd0, 8'h00);
        tick(10'd41, H, 4'd0, H, H);

        // Stall beats a taken branch.
        ctl(L, H, H, L, L, L, L, 10'd7, 8'h00);
        repeat (3) tick(10'd41, H, 4'd0, H, H);
        nop();
        tick(10'd42, H, 4'd0, H, H);

        // PC wraps modulo 2^A.
        ctl(L, L, H, L, L, L, L, 10'd1023, 8'h00);
        tick(10'd1023, H, 4'd0, H, H);
        nop();
        tick(10'd0, H, 4'd0, H, H);
        tick(10'd1, H, 4'd0, H, H);

        // Return wins over a simultaneous call.
        ctl(L, L, L, L, H, L, L, 10'd50, 8'h00);
        tick(10'd50, H, 4'd0, H, H);
        ctl(L, L, L, L, H, H, L, 10'd900, 8'h00);
        tick(10'd2, H, 4'd0, H, H);
        ctl(L, L, L, L, L, H, L, 10'd0, 8'h00);
        tick(10'd3, H, 4'd0, H, H);

        // Program 1: one-cycle pulse, call ignored, stack cleared.
        ctl(L, L, L, L, H, L, L, 10'd60, 8'h00);
        tick(10'd60, H, 4'd0, H, H);
        ctl(H, L, L, L, H, L, L, 10'd900, 8'h00);
        tick(10'd60, L, 4'd1, H, H);
        nop();
        tick(10'd100, H, 4'd1, H, H);
        ctl(L, L, L, L, L, H, L, 10'd0, 8'h00);
        tick(10'd101, H, 4'd1, H, H);

        // Program 2, then wrap to program 0.
        ctl(H, L, L, L, L, L, L, 10'd0, 8'h00);
        tick(10'd101, L, 4'd2, H, H);
        nop();
        tick(10'd200, H, 4'd2, H, H);
        ctl(H, L, L, L, L, L, L, 10'd0, 8'h00);
        tick(10'd200, L, 4'd0, H, H);
        nop();
        tick(10'd0, H, 4'd0, H, H);

        // Reset in HOLD, next Start selects program 0.
        ctl(H, L, L, L, L, L, L, 10'd0, 8'h00);
        tick(10'd0, L, 4'd1, H, H);
        Reset = 1'b1;
        tick(10'd0, L, 4'd0, L, L);
        Reset = 1'b0;
        tick(10'd0, L, 4'd0, L, L);
        nop();
        tick(10'd0, H, 4'd0, L, L);
        tick(10'd1, H, 4'd0, L, L);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge Clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
